// File: rtl/tdc_pkg.sv
// Shared widths, types and helpers for the TDC sum reader.
package tdc_pkg;

    localparam int TDC_SUM_W  = 20;
    localparam int TDC_DROP_W = 8;

    typedef logic [TDC_SUM_W-1:0] tdc_sum_t;

    // Saturating increment for the dropped-result counter.
    function automatic logic [TDC_DROP_W-1:0] drop_inc(input logic [TDC_DROP_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + TDC_DROP_W'(1);
    endfunction

endpackage

// File: rtl/tdc_sfifo.sv
// Synchronous show-ahead FIFO: the head word is visible on dout whenever empty=0.
// Occupancy is the difference of write/read counters carrying one extra wrap bit.
module tdc_sfifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   fill
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_cnt_q, wr_cnt_d;
    logic [AW:0]      rd_cnt_q, rd_cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        fill    = wr_cnt_q - rd_cnt_q;
        empty   = (fill == '0);
        full    = (fill == (AW+1)'(DEPTH));
        do_pop  = pop && !empty && !clr;
        // A full FIFO still takes a push when the head leaves in the same cycle.
        do_push = push && (!full || do_pop) && !clr;

        wr_cnt_d = wr_cnt_q + (AW+1)'(do_push);
        rd_cnt_d = rd_cnt_q + (AW+1)'(do_pop);
        if (clr) begin
            wr_cnt_d = '0;
            rd_cnt_d = '0;
        end

        dout = empty ? '0 : mem[rd_cnt_q[AW-1:0]];
    end

    // NOTE: storage is deliberately not reset; the counters alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_cnt_q[AW-1:0]] <= din;
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

endmodule

// File: rtl/tdc_sum_reader.sv
// Averages 2^AVG_LOG2 consecutive TDC sums and queues the results for a valid/ready reader.
// Define TDC_RD_ROUND_EN for round-half-up averaging (saturating) instead of truncation.
module tdc_sum_reader
    import tdc_pkg::*;
#(
    parameter int SUM_W      = TDC_SUM_W,
    parameter int AVG_LOG2   = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SUM_W-1:0]              in_data,
    input  logic                          in_dval,
    input  logic                          clr,
    output logic [SUM_W-1:0]              rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
    output logic                          ovf,
    output logic [TDC_DROP_W-1:0]         drop_cnt
);
    localparam int ACC_W = SUM_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((2 ** AVG_LOG2) - 1);

    logic [ACC_W-1:0]      acc_q, acc_d, acc_sum;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SUM_W-1:0]      push_q, push_d, res;
    logic                  push_v_q, push_v_d;
    logic                  ovf_q, ovf_d;
    logic [TDC_DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                  fifo_empty, fifo_full, fifo_pop, drop;

`ifdef TDC_RD_ROUND_EN
    localparam logic [ACC_W:0] RND = (ACC_W+1)'((2 ** AVG_LOG2) / 2);
    logic [ACC_W:0] rnd_sum, rnd_avg;
`endif

    assign rd_valid = !fifo_empty;
    assign ovf      = ovf_q;
    assign drop_cnt = drop_cnt_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        acc_sum = acc_q + ACC_W'(in_data);
`ifdef TDC_RD_ROUND_EN
        rnd_sum = {1'b0, acc_sum} + RND;
        rnd_avg = rnd_sum >> AVG_LOG2;
        res     = (rnd_avg > (ACC_W+1)'({SUM_W{1'b1}})) ? '1 : rnd_avg[SUM_W-1:0];
`else
        res     = SUM_W'(acc_sum >> AVG_LOG2);
`endif

        acc_d    = acc_q;
        cnt_d    = cnt_q;
        push_v_d = 1'b0;
        push_d   = push_q;
        if (in_dval) begin
            // The closing sample resets the window in the same cycle, so windows abut.
            if (cnt_q == CNT_LAST) begin
                acc_d    = '0;
                cnt_d    = '0;
                push_v_d = 1'b1;
                push_d   = res;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        fifo_pop   = rd_valid && rd_ready;
        drop       = push_v_q && fifo_full && !fifo_pop;
        ovf_d      = ovf_q || drop;
        drop_cnt_d = drop ? drop_inc(drop_cnt_q) : drop_cnt_q;

        if (clr) begin
            acc_d      = '0;
            cnt_d      = '0;
            push_v_d   = 1'b0;
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            push_q     <= '0;
            push_v_q   <= 1'b0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            push_q     <= push_d;
            push_v_q   <= push_v_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    tdc_sfifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SUM_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push_v_q),
        .din   (push_q),
        .pop   (fifo_pop),
        .dout  (rd_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .fill  (fill)
    );

endmodule

// File: tb/tb_tdc_sum_reader.sv
// Scoreboard bench for tdc_sum_reader: instance 0 averages 4 samples, instance 1 is pass-through.
// Expected rounding follows TDC_RD_ROUND_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_tdc_sum_reader;

    localparam int SUM_W = 20;
    localparam int DEPTH = 16;
    localparam int NI    = 2;
    localparam logic [SUM_W-1:0] MAXV = '1;
`ifdef TDC_RD_ROUND_EN
    localparam logic [SUM_W-1:0] EXP_101 = 20'd102;
`else
    localparam logic [SUM_W-1:0] EXP_101 = 20'd101;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [SUM_W-1:0] in_data  [NI];
    logic             in_dval  [NI];
    logic             clr      [NI];
    logic             rd_ready [NI];
    logic [SUM_W-1:0] rd_data  [NI];
    logic             rd_valid [NI];
    logic [4:0]       fill     [NI];
    logic             ovf      [NI];
    logic [7:0]       drop_cnt [NI];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Mean of a closed window, as the block is meant to report it.
    function automatic logic [SUM_W-1:0] model_avg(input longint unsigned s, input int a);
        longint unsigned r;
`ifdef TDC_RD_ROUND_EN
        r = (s + ((64'd1 << a) >> 1)) >> a;
        if (r > 64'(MAXV)) r = 64'(MAXV);
`else
        r = s >> a;
`endif
        return r[SUM_W-1:0];
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int AVG = (g == 0) ? 2 : 0;

        logic [SUM_W-1:0] exp_q [$];
        logic [SUM_W-1:0] pend_val;
        logic             pend_v;
        longint unsigned  win_sum;
        int               win_n;
        int               m_drops;
        logic             m_ovf;

        tdc_sum_reader #(
            .SUM_W      (SUM_W),
            .AVG_LOG2   (AVG),
            .FIFO_DEPTH (DEPTH)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_data  (in_data[g]),
            .in_dval  (in_dval[g]),
            .clr      (clr[g]),
            .rd_data  (rd_data[g]),
            .rd_valid (rd_valid[g]),
            .rd_ready (rd_ready[g]),
            .fill     (fill[g]),
            .ovf      (ovf[g]),
            .drop_cnt (drop_cnt[g])
        );

        // Reference model: windows close after 2^AVG samples, results land in the queue one edge later.
        initial begin : model
            pend_v   = 1'b0;
            pend_val = '0;
            win_sum  = 0;
            win_n    = 0;
            m_drops  = 0;
            m_ovf    = 1'b0;
            forever begin
                @(posedge clk or negedge rst);
                if (!rst || clr[g]) begin
                    exp_q.delete();
                    pend_v  = 1'b0;
                    win_sum = 0;
                    win_n   = 0;
                    m_drops = 0;
                    m_ovf   = 1'b0;
                end else begin
                    if (pend_v) begin
                        // The monitor has already removed this cycle's popped entry.
                        if (exp_q.size() < DEPTH) begin
                            exp_q.push_back(pend_val);
                        end else begin
                            m_ovf = 1'b1;
                            if (m_drops < 255) m_drops++;
                        end
                    end
                    pend_v = 1'b0;
                    if (in_dval[g]) begin
                        win_sum += longint'(in_data[g]);
                        win_n++;
                        if (win_n == (1 << AVG)) begin
                            pend_val = model_avg(win_sum, AVG);
                            pend_v   = 1'b1;
                            win_sum  = 0;
                            win_n    = 0;
                        end
                    end
                end
            end
        end

        initial begin : monitor
            forever begin
                @(negedge clk);
                if (!rst) begin
                    check($sformatf("u%0d_rst_valid", g), 64'(rd_valid[g]), 64'd0);
                    check($sformatf("u%0d_rst_data", g), 64'(rd_data[g]), 64'd0);
                    check($sformatf("u%0d_rst_fill", g), 64'(fill[g]), 64'd0);
                    check($sformatf("u%0d_rst_ovf", g), 64'(ovf[g]), 64'd0);
                    check($sformatf("u%0d_rst_drop", g), 64'(drop_cnt[g]), 64'd0);
                end else begin
                    check($sformatf("u%0d_fill", g), 64'(fill[g]), 64'(exp_q.size()));
                    check($sformatf("u%0d_valid", g), 64'(rd_valid[g]), 64'(exp_q.size() != 0));
                    check($sformatf("u%0d_ovf", g), 64'(ovf[g]), 64'(m_ovf));
                    check($sformatf("u%0d_drop", g), 64'(drop_cnt[g]), 64'(m_drops));
                    if (rd_valid[g] && rd_ready[g] && exp_q.size() != 0) begin
                        check($sformatf("u%0d_data", g), 64'(rd_data[g]), 64'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic [SUM_W-1:0] d);
        in_dval[i] = 1'b1;
        in_data[i] = d;
        step();
        in_dval[i] = 1'b0;
    endtask

    // Feeds a 4-sample window into instance 0 and checks the exact output timing and value.
    task automatic window4(input string name, input logic [SUM_W-1:0] d, input logic [SUM_W-1:0] exp);
        for (int k = 0; k < 4; k++) send(0, d + SUM_W'(k * (d == 20'd100 ? 1 : 0)));
        check({name, "_early"}, 64'(rd_valid[0]), 64'd0);
        step();
        check({name, "_valid"}, 64'(rd_valid[0]), 64'd1);
        check({name, "_data"}, 64'(rd_data[0]), 64'(exp));
        step();
        check({name, "_pulse"}, 64'(rd_valid[0]), 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            in_data[i]  = '0;
            in_dval[i]  = 1'b0;
            clr[i]      = 1'b0;
            rd_ready[i] = 1'b1;
        end
        repeat (3) step();
        rst = 1'b1;
        step();

        // Averaging: 100..103 and a full-scale window.
        window4("avg_100", 20'd100, EXP_101);
        window4("avg_max", MAXV, MAXV);

        // Pass-through overflow: 17 results into a 16-deep FIFO with no reader.
        rd_ready[1] = 1'b0;
        for (int v = 1; v <= 17; v++) send(1, SUM_W'(v));
        step();
        check("ovf17_fill", 64'(fill[1]), 64'd16);
        check("ovf17_ovf", 64'(ovf[1]), 64'd1);
        check("ovf17_drop", 64'(drop_cnt[1]), 64'd1);
        rd_ready[1] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            check($sformatf("order_%0d", k), 64'(rd_data[1]), 64'(k));
            step();
        end
        check("drained_valid", 64'(rd_valid[1]), 64'd0);
        rd_ready[1] = 1'b0;

        clr[1] = 1'b1;
        step();
        clr[1] = 1'b0;
        check("clr1_ovf", 64'(ovf[1]), 64'd0);
        check("clr1_drop", 64'(drop_cnt[1]), 64'd0);

        // Full FIFO with a simultaneous pop: the push is accepted.
        for (int v = 201; v <= 217; v++) send(1, SUM_W'(v));
        check("full_fill", 64'(fill[1]), 64'd16);
        rd_ready[1] = 1'b1;
        step();
        rd_ready[1] = 1'b0;
        check("pushpop_fill", 64'(fill[1]), 64'd16);
        check("pushpop_ovf", 64'(ovf[1]), 64'd0);
        check("pushpop_drop", 64'(drop_cnt[1]), 64'd0);

        // Three drops, shrink to five entries, then clear.
        for (int v = 218; v <= 220; v++) send(1, SUM_W'(v));
        step();
        check("drop3_cnt", 64'(drop_cnt[1]), 64'd3);
        rd_ready[1] = 1'b1;
        repeat (11) step();
        rd_ready[1] = 1'b0;
        check("pre_clr_fill", 64'(fill[1]), 64'd5);
        check("pre_clr_ovf", 64'(ovf[1]), 64'd1);
        check("pre_clr_drop", 64'(drop_cnt[1]), 64'd3);
        clr[1] = 1'b1;
        step();
        clr[1] = 1'b0;
        check("clr_fill", 64'(fill[1]), 64'd0);
        check("clr_valid", 64'(rd_valid[1]), 64'd0);
        check("clr_ovf", 64'(ovf[1]), 64'd0);
        check("clr_drop", 64'(drop_cnt[1]), 64'd0);

        // Partial window lost across reset, then across clr.
        send(0, 20'd50);
        send(0, 20'd50);
        rst = 1'b0;
        step();
        rst = 1'b1;
        window4("after_rst", 20'd10, 20'd10);
        send(0, 20'd50);
        send(0, 20'd50);
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        window4("after_clr", 20'd10, 20'd10);

        // Drop counter saturation.
        for (int v = 0; v < DEPTH + 260; v++) send(1, SUM_W'(v));
        step();
        check("drop_sat", 64'(drop_cnt[1]), 64'd255);
        clr[1] = 1'b1;
        step();
        clr[1] = 1'b0;

        // Randomised traffic with alternating slow and fast readers and occasional clears.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NI; i++) begin
                in_dval[i]  = ($urandom_range(0, 9) < 6);
                in_data[i]  = ($urandom_range(0, 7) == 0) ? MAXV : SUM_W'($urandom);
                rd_ready[i] = ((c % 400) < 200) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
                clr[i]      = ($urandom_range(0, 199) == 0);
            end
            step();
        end

        for (int i = 0; i < NI; i++) begin
            in_dval[i]  = 1'b0;
            clr[i]      = 1'b0;
            rd_ready[i] = 1'b1;
        end
        repeat (40) step();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("final_valid%0d", i), 64'(rd_valid[i]), 64'd0);
            check($sformatf("final_fill%0d", i), 64'(fill[i]), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tdc_sum_reader.md
Name: tdc_sum_reader

Overview:
Downstream consumer of the 8-channel TDC summation pipeline. Takes the 20-bit summed time word and its one-cycle valid strobe and averages 2^AVG_LOG2 consecutive sums. Results go into a show-ahead FIFO that host-side logic drains through a valid/ready read port. Tracks dropped results and sticky overflow.

Parameters:
SUM_W, 20, width of the incoming sum word and of the averaged result.
AVG_LOG2, 2, log2 of the averaging window; legal range 0..8, where 0 means pass-through.
FIFO_DEPTH, 16, number of result FIFO entries; must be a power of 2, at least 2.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous active-low reset (despite the name, low = reset).
in_data  in  SUM_W  summed TDC word from the summation pipeline.
in_dval  in  1  in_data valid; may be high on consecutive cycles.
clr  in  1  synchronous clear of the accumulator, sample count, FIFO, ovf and drop_cnt.
rd_data  out  SUM_W  FIFO head word; meaningful only while rd_valid=1.
rd_valid  out  1  FIFO not empty.
rd_ready  in  1  consumer accepts the head word; a pop happens when rd_valid&&rd_ready.
fill  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
ovf  out  1  sticky: at least one result was dropped because the FIFO was full.
drop_cnt  out  8  number of dropped results; saturates at 255.

Behaviour:
- Reset: one clock (clk), asynchronous active-low reset (rst). All state clears on reset: acc=0, cnt=0, FIFO empty, rd_valid=0, rd_data=0, fill=0, ovf=0, drop_cnt=0.
- Accumulator width is SUM_W+AVG_LOG2, so it never overflows.
- Each cycle with in_dval=1: acc += in_data and cnt++.
- Window close: on the in_dval where cnt==2^AVG_LOG2-1:
  - res = (acc+in_data) >> AVG_LOG2, truncated to SUM_W bits;
  - res is registered into push_q with push_v=1;
  - acc and cnt return to 0 in the same cycle, so a new window can start on the next in_dval with no gap.
- Pass-through: with AVG_LOG2=0 every in_dval closes a window.
- Push: push_v pushes push_q into the FIFO on the following edge.
- Latency: rd_valid rises 2 cycles after the closing in_dval edge when the FIFO was empty. Sequence: edge N samples the closing in_dval, edge N+1 writes the FIFO, rd_valid=1 after edge N+1.
- Show-ahead read: rd_data shows the head word combinationally from FIFO storage. A pop advances the head on the next edge.
- Full FIFO push:
  - If rd_ready&&rd_valid in the same cycle, the push is accepted and fill is unchanged.
  - Otherwise the result is dropped, ovf<=1 and drop_cnt increments, saturating at 255.
- Empty FIFO: rd_ready is ignored and no pointer moves.
- Simultaneous push+pop on an empty FIFO: pop is impossible (rd_valid=0), so only the push happens.
- clr has priority over in_dval, push and pop in the same cycle. The partial window and any pending push_q are discarded.
- Reset mid-window: the partial window is lost. The first window after reset starts on the first in_dval.
- Pointers wrap modulo FIFO_DEPTH. fill = wr_cnt - rd_cnt using one extra bit.

Optional Feature:
Macro TDC_RD_ROUND_EN.
- Defined: res = (acc+in_data + 2^(AVG_LOG2-1)) >> AVG_LOG2, i.e. round half-up. If the rounded value exceeds 2^SUM_W-1 it saturates to 2^SUM_W-1. With AVG_LOG2=0 no rounding constant is added.
- Undefined: truncating shift, as in Behaviour.
- Latency is identical in both builds.

Decomposition:
- Package tdc_pkg holds:
  - localparam TDC_SUM_W=20;
  - typedef logic[TDC_SUM_W-1:0] tdc_sum_t;
  - drop counter width, localparam TDC_DROP_W=8.
- Sub-module tdc_sfifo: synchronous show-ahead FIFO with DEPTH and WIDTH parameters and ports clk, rst, clr, push, din, pop, dout, empty, full, fill. tdc_sum_reader instantiates it once. The accumulator/window logic stays in the top block.

Test Plan:
- AVG_LOG2=2, in_data 100,101,102,103 on consecutive cycles, rd_ready=1 -> rd_valid pulses one cycle with rd_data=101 (truncating build) or 102 (TDC_RD_ROUND_EN build); rd_valid rises 2 cycles after the 4th in_dval edge.
- AVG_LOG2=2, four samples of 0xFFFFF -> rd_data=0xFFFFF in both builds, no wrap.
- AVG_LOG2=0, rd_ready=0, 17 back-to-back in_dval of 1..17 -> fill=16, ovf=1, drop_cnt=1. Popping all entries gives 1..16 in order, then rd_valid=0.
- FIFO full, one window closes while rd_ready=1 -> push accepted, fill stays 16, ovf stays 0.
- AVG_LOG2=2, two samples of 50, then rst low for 1 cycle, then 4 samples of 10 -> single result 10. Two samples of 50, then clr, then 4 samples of 10 -> single result 10.
- clr asserted with FIFO holding 5 entries, ovf=1 and drop_cnt=3 -> next cycle fill=0, rd_valid=0, ovf=0, drop_cnt=0.
